// File: rtl/ram_dual_be_if.sv
// Access port bundle for ram_dual_be.
// One instance per RAM port; master = requester, slave = RAM.
interface ram_dual_be_if #(
  parameter int AW = 12,
  parameter int DW = 16,
  parameter int NL = 2
);
  logic          en;
  logic [NL-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] write;
  logic [DW-1:0] read;
  logic          rvalid;

  modport master (
    output en, we, addr, write,
    input  read, rvalid
  );

  modport slave (
    input  en, we, addr, write,
    output read, rvalid
  );
endinterface

// File: rtl/ram_dual_be.sv
// True dual-port byte-enable RAM for the j1a program/data store.
// Port A: CPU fetch/data path. Port B: host loader and DMA.
module ram_dual_be #(
  parameter string MEM_INIT_FILE = "",
  parameter int    LOG2ABITS     = 12,
  parameter int    DWIDTH        = 16,
  parameter int    BYTEW         = 8,
  parameter int    RDW_MODE      = 0,
  parameter int    OUT_REG       = 0
) (
  input  logic           clk,
  input  logic           resetq,
  ram_dual_be_if.slave   pa,
  ram_dual_be_if.slave   pb,
  output logic           collision
);

  localparam int NLANES = DWIDTH / BYTEW;
  localparam int DEPTH  = 1 << LOG2ABITS;
  localparam bit WF     = (RDW_MODE == 1);
  localparam bit NC     = (RDW_MODE == 2);

  logic [DWIDTH-1:0] mem [DEPTH];

  function automatic logic [DWIDTH-1:0] merge(
    input logic [DWIDTH-1:0] old,
    input logic [DWIDTH-1:0] nw,
    input logic [NLANES-1:0] we
  );
    logic [DWIDTH-1:0] r;
    r = old;
    for (int i = 0; i < NLANES; i++)
      if (we[i])
        r[i*BYTEW +: BYTEW] = nw[i*BYTEW +: BYTEW];
    return r;
  endfunction

  logic              wa, wb, same;
  logic              goa, gob;
  logic [DWIDTH-1:0] olda, oldb;

  assign wa   = |pa.we;
  assign wb   = |pb.we;
  assign same = (pa.addr == pb.addr);
  assign olda = mem[pa.addr];
  assign oldb = mem[pb.addr];
  assign goa  = pa.en && !(NC && wa);
  assign gob  = pb.en && !(NC && wb);

  always_ff @(posedge clk) begin
    if (resetq) begin
      for (int i = 0; i < NLANES; i++) begin
        if (pa.en && pa.we[i])
          mem[pa.addr][i*BYTEW +: BYTEW] <=
            pa.write[i*BYTEW +: BYTEW];
        if (pb.en && pb.we[i] &&
            !(pa.en && pa.we[i] && same))
          mem[pb.addr][i*BYTEW +: BYTEW] <=
            pb.write[i*BYTEW +: BYTEW];
      end
    end
  end

  logic [DWIDTH-1:0] rd1a, rd1b;
  logic              rv1a, rv1b;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd1a      <= '0;
      rd1b      <= '0;
      rv1a      <= 1'b0;
      rv1b      <= 1'b0;
      collision <= 1'b0;
    end else begin
      rv1a <= goa;
      rv1b <= gob;
      if (goa)
        rd1a <= (WF && wa) ?
                merge(olda, pa.write, pa.we) : olda;
      if (gob)
        rd1b <= (WF && wb) ?
                merge(oldb, pb.write, pb.we) : oldb;
      collision <= pa.en && pb.en && same &&
                   (wa || wb);
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DWIDTH-1:0] rd2a, rd2b;
    logic              rv2a, rv2b;

    always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
        rd2a <= '0;
        rd2b <= '0;
        rv2a <= 1'b0;
        rv2b <= 1'b0;
      end else begin
        rd2a <= rd1a;
        rd2b <= rd1b;
        rv2a <= rv1a;
        rv2b <= rv1b;
      end
    end

    assign pa.read   = rd2a;
    assign pa.rvalid = rv2a;
    assign pb.read   = rd2b;
    assign pb.rvalid = rv2b;
  end else begin : g_noreg
    assign pa.read   = rd1a;
    assign pa.rvalid = rv1a;
    assign pb.read   = rd1b;
    assign pb.rvalid = rv1b;
  end

endmodule
